// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage with a small FIFO fetch buffer in front of decode.
// A PC register addresses a combinational instruction ROM. Each fetched
// {pc, inst} pair is pushed into the buffer, and decode pops it from the head
// with a valid/ready handshake. A redirect flushes the buffer and reloads
// the PC with the word-aligned target.
//
// Ports
//   clock        in   sole clock, rising edge
//   resetn       in   asynchronous active-low reset
//   inst_addr    out  [31:0] fetch address to the ROM (straight from the PC)
//   inst_in      in   [31:0] ROM word for inst_addr, same cycle
//   redirect     in   flush and reload the PC
//   redirect_pc  in   [31:0] redirect target (low two bits ignored)
//   dec_valid    out  buffer head is valid
//   dec_ready    in   decode takes the head this cycle
//   dec_inst     out  [31:0] head instruction (0 when empty)
//   dec_pc       out  [31:0] head address (0 when empty)
//   level        out  [2:0] buffer occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [2:0]  level
);

    localparam logic [2:0] DEPTH_L  = 3'(DEPTH);
    localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);

    // Storage is always sized for the largest legal DEPTH so that the 2-bit
    // pointers index it cleanly; only entries 0..DEPTH-1 are ever used.
    logic [31:0] buf_pc_r   [4];
    logic [31:0] buf_inst_r [4];
    logic [31:0] pc_r;
    logic [1:0]  head_r;
    logic [1:0]  tail_r;
    logic [2:0]  count_r;
    logic        pop_s;
    logic        fetch_s;
    logic        unused_low_bits_s;

    // Pointer advance with wrap at DEPTH (DEPTH=3 is not a power of two).
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        if (p == LAST_PTR) begin
            return 2'd0;
        end else begin
            return p + 2'd1;
        end
    endfunction

    // The two low target bits are dropped by the word alignment.
    assign unused_low_bits_s = ^redirect_pc[1:0];

    // Handshake decode: a redirect suppresses both pop and fetch.
    always_comb begin
        pop_s   = (count_r != 3'd0) & dec_ready & ~redirect;
        fetch_s = ~redirect & ((count_r < DEPTH_L) | pop_s);
    end

    // PC, pointers and occupancy.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_r    <= RESET_PC;
            head_r  <= 2'd0;
            tail_r  <= 2'd0;
            count_r <= 3'd0;
        end else if (redirect) begin
            pc_r    <= {redirect_pc[31:2], 2'b00};
            head_r  <= 2'd0;
            tail_r  <= 2'd0;
            count_r <= 3'd0;
        end else begin
            if (fetch_s) begin
                pc_r   <= pc_r + 32'd4;
                tail_r <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({fetch_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Buffer entry write at the tail; cleared on reset so no stale data
    // survives into a new run.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                buf_pc_r[i]   <= 32'h0000_0000;
                buf_inst_r[i] <= 32'h0000_0000;
            end
        end else if (fetch_s) begin
            buf_pc_r[tail_r]   <= pc_r;
            buf_inst_r[tail_r] <= inst_in;
        end
    end

    // Head presentation; zeroed when the buffer is empty.
    always_comb begin
        inst_addr = pc_r;
        level     = count_r;
        dec_valid = (count_r != 3'd0);
        if (count_r != 3'd0) begin
            dec_inst = buf_inst_r[head_r];
            dec_pc   = buf_pc_r[head_r];
        end else begin
            dec_inst = 32'h0000_0000;
            dec_pc   = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. The ROM is modelled as inst = addr ^ rom_key
// so that instruction and address fields are distinguishable.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clock;
    logic        resetn;
    logic [31:0] inst_addr;
    logic [31:0] inst_in;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [2:0]  level;
    logic [31:0] rom_key;

    int n_tests;
    int n_fail;

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .inst_addr   (inst_addr),
        .inst_in     (inst_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .level       (level)
    );

    assign inst_in = inst_addr ^ rom_key;

    // Free-running clock, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        resetn      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        dec_ready   = 1'b1;
        rom_key     = 32'h0000_0000;

        // Reset state
        tick();
        tick();
        check("rst_addr",  inst_addr, 32'h0000_0000);
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_inst",  dec_inst, 32'h0000_0000);
        check("rst_pc",    dec_pc, 32'h0000_0000);

        // Stream with ROM word = address
        #2 resetn = 1'b1;
        tick();
        check("str_valid", 32'(dec_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("str_pc",    dec_pc, 32'(4 * i));
            check("str_inst",  dec_inst, 32'(4 * i));
            check("str_level", 32'(level), 32'd1);
            tick();
        end

        // Backpressure
        resetn    = 1'b0;
        dec_ready = 1'b0;
        rom_key   = 32'hDEAD_0000;
        #2 resetn = 1'b1;
        tick();
        check("bp_first_valid", 32'(dec_valid), 32'd1);
        check("bp_first_pc",    dec_pc, 32'h0000_0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_pc",   dec_pc, 32'h0000_0000);
            check("bp_hold_inst", dec_inst, 32'hDEAD_0000);
        end
        check("bp_level", 32'(level), 32'd2);
        check("bp_addr",  inst_addr, 32'h0000_0008);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain_valid", 32'(dec_valid), 32'd1);
            check("bp_drain_pc",    dec_pc, 32'(4 * i));
            check("bp_drain_inst",  dec_inst, 32'(4 * i) ^ 32'hDEAD_0000);
            tick();
        end
        check("bp_drain_level", 32'(level), 32'd2);

        // Redirect with a full buffer, target not word aligned
        dec_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0123;
        tick();
        redirect = 1'b0;
        check("rd_level", 32'(level), 32'd0);
        check("rd_valid", 32'(dec_valid), 32'd0);
        check("rd_addr",  inst_addr, 32'h0000_0120);
        check("rd_pc0",   dec_pc, 32'h0000_0000);
        tick();
        check("rd_tvalid", 32'(dec_valid), 32'd1);
        check("rd_tpc",    dec_pc, 32'h0000_0120);
        check("rd_tinst",  dec_inst, 32'h0000_0120 ^ 32'hDEAD_0000);
        tick();
        check("rd_fill", 32'(level), 32'd2);

        // Redirect together with dec_ready at level 2
        dec_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        tick();
        redirect  = 1'b0;
        dec_ready = 1'b0;
        check("sim_level", 32'(level), 32'd0);
        check("sim_addr",  inst_addr, 32'h0000_0400);
        tick();
        check("sim_pc", dec_pc, 32'h0000_0400);

        // Back-to-back redirects: last wins
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0500;
        tick();
        redirect_pc = 32'h0000_0600;
        tick();
        redirect = 1'b0;
        check("b2b_level", 32'(level), 32'd0);
        check("b2b_addr",  inst_addr, 32'h0000_0600);
        dec_ready = 1'b1;
        tick();
        check("b2b_pc0", dec_pc, 32'h0000_0600);
        tick();
        check("b2b_pc1", dec_pc, 32'h0000_0604);

        // Wrap past the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        check("wr_addr", inst_addr, 32'hFFFF_FFFC);
        tick();
        check("wr_pc0",   dec_pc, 32'hFFFF_FFFC);
        check("wr_inst0", dec_inst, 32'hFFFF_FFFC ^ 32'hDEAD_0000);
        check("wr_addr1", inst_addr, 32'h0000_0000);
        tick();
        check("wr_pc1",   dec_pc, 32'h0000_0000);
        check("wr_inst1", dec_inst, 32'hDEAD_0000);

        // Asynchronous reset mid-cycle with a full buffer
        dec_ready = 1'b0;
        tick();
        check("ar_fill", 32'(level), 32'd2);
        #2 resetn = 1'b0;
        #1;
        check("ar_valid", 32'(dec_valid), 32'd0);
        check("ar_level", 32'(level), 32'd0);
        check("ar_pc",    dec_pc, 32'h0000_0000);
        check("ar_addr",  inst_addr, 32'h0000_0000);
        resetn    = 1'b1;
        dec_ready = 1'b1;
        tick();
        check("ar_rel_valid", 32'(dec_valid), 32'd1);
        check("ar_rel_pc",    dec_pc, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
